// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage sitting directly in front of the IF/ID register.
// It owns the fetch PC and keeps at most one request open on the
// instruction memory port. It presents one {pc, inst} entry to IF/ID,
// honouring the shared stall, and drops responses made stale by a redirect.
// Optional build macro FETCH_ADEL_EN: a misaligned fetch PC is not sent to
// memory. Instead it produces a single address-error entry flagged on if_adel_o.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_addr_ok_i,
   input  logic        inst_data_ok_i,
   input  logic [31:0] inst_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
`ifdef FETCH_ADEL_EN
   output logic        if_adel_o,
`endif
   output logic        if_valid_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

`ifdef FETCH_ADEL_EN
   // Misaligned targets are kept so they can be reported as address errors.
   localparam logic [31:0] RESET_PC_EFF = RESET_PC;
`else
   // Without address-error reporting the low PC bits are always forced to zero.
   localparam logic [31:0] RESET_PC_EFF = RESET_PC & 32'hFFFF_FFFC;
`endif

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic        out_valid_q;
   logic [31:0] out_pc_q;
   logic [31:0] out_inst_q;

   logic        out_free;
   logic        consume;
   logic        pc_misaligned;
   logic        fetch_ok;
   logic        accept;
   logic [31:0] redirect_target;

`ifdef FETCH_ADEL_EN
   logic        adel_q;
   logic        adel_sent_q;
`endif

   // Derive the handshake qualifiers from the current state and output register.
   always_comb begin
      out_free = !out_valid_q || !stall_i;
      consume  = out_valid_q && !stall_i;
`ifdef FETCH_ADEL_EN
      pc_misaligned   = (pc_q[1:0] != 2'b00);
      redirect_target = redirect_pc_i;
`else
      pc_misaligned   = 1'b0;
      redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
`endif
      fetch_ok = (state_q == S_REQ) && out_free && !pc_misaligned;
      accept   = fetch_ok && inst_addr_ok_i;
   end

   assign inst_req_o  = rst_i && fetch_ok;
   assign inst_addr_o = pc_q;
   assign if_pc_o     = out_pc_q;
   assign if_inst_o   = out_valid_q ? out_inst_q : 32'h0;
   assign if_valid_o  = out_valid_q;
`ifdef FETCH_ADEL_EN
   assign if_adel_o   = adel_q;
`endif

   // Fetch FSM, PC and output register.
   // A redirect overrides everything else in its cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC_EFF;
         req_pc_q    <= 32'h0;
         out_valid_q <= 1'b0;
         out_pc_q    <= 32'h0;
         out_inst_q  <= 32'h0;
`ifdef FETCH_ADEL_EN
         adel_q      <= 1'b0;
         adel_sent_q <= 1'b0;
`endif
      end else if (redirect_i) begin
         pc_q        <= redirect_target;
         out_valid_q <= 1'b0;
`ifdef FETCH_ADEL_EN
         adel_q      <= 1'b0;
         adel_sent_q <= 1'b0;
`endif
         case (state_q)
            S_REQ:   state_q <= accept ? S_DROP : S_REQ;
            S_WAIT:  state_q <= inst_data_ok_i ? S_REQ : S_DROP;
            S_DROP:  state_q <= inst_data_ok_i ? S_REQ : S_DROP;
            default: state_q <= S_REQ;
         endcase
      end else begin
         if (consume) begin
            out_valid_q <= 1'b0;
`ifdef FETCH_ADEL_EN
            adel_q      <= 1'b0;
`endif
         end
         case (state_q)
            S_REQ: begin
`ifdef FETCH_ADEL_EN
               if (pc_misaligned && out_free && !adel_sent_q) begin
                  out_valid_q <= 1'b1;
                  out_pc_q    <= pc_q;
                  out_inst_q  <= 32'h0;
                  adel_q      <= 1'b1;
                  adel_sent_q <= 1'b1;
               end
`endif
               if (accept) begin
                  req_pc_q <= pc_q;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (inst_data_ok_i) begin
                  out_valid_q <= 1'b1;
                  out_pc_q    <= req_pc_q;
                  out_inst_q  <= inst_rdata_i;
                  pc_q        <= req_pc_q + PC_STEP;
                  state_q     <= S_REQ;
               end
            end
            S_DROP: begin
               if (inst_data_ok_i) begin
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

endmodule
